// File: rtl/pack_bist_sequencer.sv
// BIST controller: holds the core in reset, drives LFSR stimulus, compresses outa..outd
// into a 16-bit MISR and compares against GOLDEN. Optional macro: CEN_RANDOM_EN.
module pack_bist_sequencer #(
  parameter int          RST_CYCLES   = 4,
  parameter int          RUN_CYCLES   = 256,
  parameter int          DRAIN_CYCLES = 2,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1,
  parameter logic [15:0] GOLDEN       = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  output logic        core_rst,
  output logic        core_cen,
  output logic        core_ina,
  output logic        core_inb,
  input  logic        core_outa,
  input  logic        core_outb,
  input  logic        core_outc,
  input  logic        core_outd,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] signature
);

  localparam int MAX_A = (RST_CYCLES > RUN_CYCLES) ? RST_CYCLES : RUN_CYCLES;
  localparam int MAX_C = (MAX_A > DRAIN_CYCLES) ? MAX_A : DRAIN_CYCLES;
  localparam int CW    = $clog2(MAX_C + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RESET = 3'd1,
    S_RUN   = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  // Shared feedback for both the stimulus LFSR and the MISR (taps 16,14,13,11).
  function automatic logic tap_fb(input logic [15:0] v);
    return v[15] ^ v[13] ^ v[12] ^ v[10];
  endfunction

  state_t        state_r;
  logic [CW-1:0] cnt_r;
  logic [15:0]   lfsr_r;
  logic [15:0]   misr_r;

  logic [15:0]   lfsr_nxt_s;
  logic [15:0]   misr_nxt_s;
  logic          adv_s;
  logic          last_s;
  logic          cen_run_s;

  // Next LFSR/MISR values, advance qualifier and end-of-phase detection.
  always_comb begin
    lfsr_nxt_s = lfsr_r;
    misr_nxt_s = misr_r;
    adv_s      = 1'b0;
    last_s     = 1'b0;
    cen_run_s  = 1'b1;
    if (state_r == S_RUN) begin
      lfsr_nxt_s = {lfsr_r[14:0], tap_fb(lfsr_r)};
    end else begin
      lfsr_nxt_s = lfsr_r;
    end
`ifdef CEN_RANDOM_EN
    cen_run_s = lfsr_nxt_s[2];
`else
    cen_run_s = 1'b1;
`endif
    // core_cen is the registered enable the core actually sees this cycle.
    if (((state_r == S_RUN) || (state_r == S_DRAIN)) && core_cen) begin
      adv_s      = 1'b1;
      misr_nxt_s = {misr_r[14:0], tap_fb(misr_r)}
                 ^ {12'b0, core_outd, core_outc, core_outb, core_outa};
    end else begin
      adv_s      = 1'b0;
      misr_nxt_s = misr_r;
    end
    case (state_r)
      S_RESET: last_s = (cnt_r == CW'(RST_CYCLES - 1));
      S_RUN:   last_s = adv_s && (cnt_r == CW'(RUN_CYCLES - 1));
      S_DRAIN: last_s = (DRAIN_CYCLES > 0) && (cnt_r == CW'(DRAIN_CYCLES - 1));
      default: last_s = 1'b0;
    endcase
  end

  // Sequencer FSM with all outputs registered from the state being entered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r   <= S_IDLE;
      cnt_r     <= '0;
      lfsr_r    <= LFSR_SEED;
      misr_r    <= 16'h0000;
      core_rst  <= 1'b1;
      core_cen  <= 1'b0;
      core_ina  <= 1'b0;
      core_inb  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      signature <= 16'h0000;
    end else begin
      done   <= 1'b0;
      lfsr_r <= lfsr_nxt_s;
      misr_r <= misr_nxt_s;
      if (abort) begin
        state_r  <= S_IDLE;
        cnt_r    <= '0;
        core_rst <= 1'b1;
        core_cen <= 1'b0;
        core_ina <= 1'b0;
        core_inb <= 1'b0;
        busy     <= 1'b0;
        pass     <= 1'b0;
      end else begin
        case (state_r)
          S_IDLE: begin
            if (start) begin
              state_r <= S_RESET;
              cnt_r   <= '0;
              lfsr_r  <= LFSR_SEED;
              misr_r  <= 16'h0000;
              busy    <= 1'b1;
              pass    <= 1'b0;
            end
          end
          S_RESET: begin
            if (last_s) begin
              state_r  <= S_RUN;
              cnt_r    <= '0;
              core_rst <= 1'b0;
              core_cen <= cen_run_s;
              core_ina <= lfsr_nxt_s[0];
              core_inb <= lfsr_nxt_s[1];
            end else begin
              cnt_r <= cnt_r + CW'(1);
            end
          end
          S_RUN: begin
            if (last_s && (DRAIN_CYCLES == 0)) begin
              state_r   <= S_DONE;
              cnt_r     <= '0;
              core_rst  <= 1'b1;
              core_cen  <= 1'b0;
              core_ina  <= 1'b0;
              core_inb  <= 1'b0;
              busy      <= 1'b0;
              done      <= 1'b1;
              signature <= misr_nxt_s;
              pass      <= (misr_nxt_s == GOLDEN);
            end else if (last_s) begin
              state_r  <= S_DRAIN;
              cnt_r    <= '0;
              core_cen <= 1'b1;
              core_ina <= 1'b0;
              core_inb <= 1'b0;
            end else begin
              if (adv_s) begin
                cnt_r <= cnt_r + CW'(1);
              end
              core_cen <= cen_run_s;
              core_ina <= lfsr_nxt_s[0];
              core_inb <= lfsr_nxt_s[1];
            end
          end
          S_DRAIN: begin
            if (last_s) begin
              state_r   <= S_DONE;
              cnt_r     <= '0;
              core_rst  <= 1'b1;
              core_cen  <= 1'b0;
              busy      <= 1'b0;
              done      <= 1'b1;
              signature <= misr_nxt_s;
              pass      <= (misr_nxt_s == GOLDEN);
            end else begin
              cnt_r <= cnt_r + CW'(1);
            end
          end
          S_DONE: begin
            state_r <= S_IDLE;
            cnt_r   <= '0;
          end
          default: begin
            state_r  <= S_IDLE;
            cnt_r    <= '0;
            core_rst <= 1'b1;
            core_cen <= 1'b0;
            core_ina <= 1'b0;
            core_inb <= 1'b0;
            busy     <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pack_bist_sequencer.sv
// Directed bench: a short instance (RUN=8, outputs tied 0) and a long instance
// (RUN=256, outa looped from ina) whose GOLDEN is the bench's own signature model.
module tb_pack_bist_sequencer;

  function automatic logic [15:0] model_sig(input int run, input int drain);
    logic [15:0] l;
    logic [15:0] m;
    l = 16'hACE1;
    m = 16'h0000;
    for (int i = 0; i < run; i++) begin
      m = {m[14:0], m[15] ^ m[13] ^ m[12] ^ m[10]} ^ {15'b0, l[0]};
      l = {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    end
    for (int i = 0; i < drain; i++) begin
      m = {m[14:0], m[15] ^ m[13] ^ m[12] ^ m[10]};
    end
    return m;
  endfunction

  localparam logic [15:0] GOLD_L = model_sig(256, 2);
  localparam int          LAT_L  = 4 + 256 + 2 + 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start_s = 1'b0, abort_s = 1'b0;
  logic start_l = 1'b0, abort_l = 1'b0;
  logic inject = 1'b0;

  logic core_rst_s, core_cen_s, core_ina_s, core_inb_s, busy_s, done_s, pass_s;
  logic [15:0] sig_s;
  logic core_rst_l, core_cen_l, core_ina_l, core_inb_l, busy_l, done_l, pass_l;
  logic [15:0] sig_l;
  logic outa_l;

  int checks = 0;
  int errors = 0;

  assign outa_l = core_ina_l ^ inject;

  always #5 clk = ~clk;

  pack_bist_sequencer #(
    .RST_CYCLES(4), .RUN_CYCLES(8), .DRAIN_CYCLES(2),
    .LFSR_SEED(16'hACE1), .GOLDEN(16'h0000)
  ) u_short (
    .clk(clk), .rst(rst), .start(start_s), .abort(abort_s),
    .core_rst(core_rst_s), .core_cen(core_cen_s),
    .core_ina(core_ina_s), .core_inb(core_inb_s),
    .core_outa(1'b0), .core_outb(1'b0), .core_outc(1'b0), .core_outd(1'b0),
    .busy(busy_s), .done(done_s), .pass(pass_s), .signature(sig_s)
  );

  pack_bist_sequencer #(
    .RST_CYCLES(4), .RUN_CYCLES(256), .DRAIN_CYCLES(2),
    .LFSR_SEED(16'hACE1), .GOLDEN(GOLD_L)
  ) u_long (
    .clk(clk), .rst(rst), .start(start_l), .abort(abort_l),
    .core_rst(core_rst_l), .core_cen(core_cen_l),
    .core_ina(core_ina_l), .core_inb(core_inb_l),
    .core_outa(outa_l), .core_outb(1'b0), .core_outc(1'b0), .core_outd(1'b0),
    .busy(busy_l), .done(done_l), .pass(pass_l), .signature(sig_l)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse start on the long instance; returns with the bench in cycle 1.
  task automatic start_long();
    start_l = 1'b1;
    tick();
    start_l = 1'b0;
  endtask

  // Waits for done on the long instance, starting from cycle index c0.
  task automatic wait_done_l(input int c0, output int lat);
    int c;
    c = c0;
    while ((done_l !== 1'b1) && (c < 600)) begin
      tick();
      c++;
    end
    checks++;
    if (done_l !== 1'b1) begin
      errors++;
      $display("FAIL done_timeout got done=%b after cycle %0d", done_l, c);
    end
    lat = c;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
    repeat (5) tick();
    checks++; if (core_rst_l !== 1'b1) begin errors++; $display("FAIL reset_core_rst got %b exp 1", core_rst_l); end
    checks++; if (busy_l !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy_l); end
    checks++; if (done_l !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done_l); end
    checks++; if (pass_l !== 1'b0) begin errors++; $display("FAIL reset_pass got %b exp 0", pass_l); end
    checks++; if (sig_l !== 16'h0000) begin errors++; $display("FAIL reset_sig got %h exp 0000", sig_l); end
    checks++; if (core_cen_l !== 1'b0) begin errors++; $display("FAIL reset_cen got %b exp 0", core_cen_l); end
  endtask

  task automatic test_short_run();
    start_s = 1'b1;
    tick();
    start_s = 1'b0;
    for (int c = 1; c <= 14; c++) begin
      checks++;
      if ((busy_s !== 1'b1) || (done_s !== 1'b0)) begin
        errors++;
        $display("FAIL short_busy cycle %0d got busy=%b done=%b exp busy=1 done=0", c, busy_s, done_s);
      end
      if (c == 4) begin
        checks++; if (core_rst_s !== 1'b1) begin errors++; $display("FAIL short_core_rst_c4 got %b exp 1", core_rst_s); end
      end
      if (c == 5) begin
        checks++;
        if ({core_rst_s, core_cen_s, core_ina_s, core_inb_s} !== 4'b0110) begin
          errors++;
          $display("FAIL short_run_c5 got rst/cen/ina/inb=%b exp 0110", {core_rst_s, core_cen_s, core_ina_s, core_inb_s});
        end
      end
      if (c == 6) begin
        checks++;
        if ({core_ina_s, core_inb_s} !== 2'b11) begin
          errors++;
          $display("FAIL short_run_c6 got ina/inb=%b exp 11", {core_ina_s, core_inb_s});
        end
      end
      if (c == 13) begin
        checks++;
        if ({core_cen_s, core_ina_s, core_inb_s} !== 3'b100) begin
          errors++;
          $display("FAIL short_drain got cen/ina/inb=%b exp 100", {core_cen_s, core_ina_s, core_inb_s});
        end
      end
      tick();
    end
    checks++; if (done_s !== 1'b1) begin errors++; $display("FAIL short_done_c15 got %b exp 1", done_s); end
    checks++; if (busy_s !== 1'b0) begin errors++; $display("FAIL short_busy_c15 got %b exp 0", busy_s); end
    checks++; if (sig_s !== 16'h0000) begin errors++; $display("FAIL short_sig got %h exp 0000", sig_s); end
    checks++; if (pass_s !== 1'b1) begin errors++; $display("FAIL short_pass got %b exp 1", pass_s); end
    tick();
    checks++; if ((done_s !== 1'b0) || (pass_s !== 1'b1)) begin errors++; $display("FAIL short_after got done=%b pass=%b exp 0 1", done_s, pass_s); end
  endtask

  task automatic test_loopback();
    int lat;
    start_long();
    wait_done_l(1, lat);
    checks++; if (lat !== LAT_L) begin errors++; $display("FAIL loop_latency got %0d exp %0d", lat, LAT_L); end
    checks++; if (sig_l !== GOLD_L) begin errors++; $display("FAIL loop_sig got %h exp %h", sig_l, GOLD_L); end
    checks++; if (pass_l !== 1'b1) begin errors++; $display("FAIL loop_pass got %b exp 1", pass_l); end
    tick();
    // Single flipped response bit during RUN must corrupt the signature.
    start_long();
    repeat (9) tick();
    inject = 1'b1;
    tick();
    inject = 1'b0;
    wait_done_l(11, lat);
    checks++; if (pass_l !== 1'b0) begin errors++; $display("FAIL flip_pass got %b exp 0", pass_l); end
    checks++; if (sig_l === GOLD_L) begin errors++; $display("FAIL flip_sig got %h exp not %h", sig_l, GOLD_L); end
    tick();
  endtask

  task automatic test_start_mid_run();
    int lat;
    start_long();
    repeat (19) tick();
    start_l = 1'b1;
    tick();
    start_l = 1'b0;
    wait_done_l(21, lat);
    checks++; if (lat !== LAT_L) begin errors++; $display("FAIL restart_latency got %0d exp %0d", lat, LAT_L); end
    checks++; if (sig_l !== GOLD_L) begin errors++; $display("FAIL restart_sig got %h exp %h", sig_l, GOLD_L); end
    checks++; if (pass_l !== 1'b1) begin errors++; $display("FAIL restart_pass got %b exp 1", pass_l); end
    tick();
  endtask

  task automatic test_abort();
    int lat;
    int seen_done;
    start_long();
    repeat (9) tick();
    abort_l = 1'b1;
    tick();
    abort_l = 1'b0;
    checks++; if (busy_l !== 1'b0) begin errors++; $display("FAIL abort_busy got %b exp 0", busy_l); end
    checks++; if (core_rst_l !== 1'b1) begin errors++; $display("FAIL abort_core_rst got %b exp 1", core_rst_l); end
    checks++; if ({core_cen_l, core_ina_l, core_inb_l} !== 3'b000) begin errors++; $display("FAIL abort_drive got %b exp 000", {core_cen_l, core_ina_l, core_inb_l}); end
    checks++; if (pass_l !== 1'b0) begin errors++; $display("FAIL abort_pass got %b exp 0", pass_l); end
    checks++; if (sig_l !== GOLD_L) begin errors++; $display("FAIL abort_sig got %h exp %h", sig_l, GOLD_L); end
    seen_done = 0;
    for (int c = 0; c < 300; c++) begin
      if (done_l === 1'b1) seen_done++;
      tick();
    end
    checks++; if (seen_done !== 0) begin errors++; $display("FAIL abort_no_done got %0d pulses exp 0", seen_done); end
    start_long();
    wait_done_l(1, lat);
    checks++; if (sig_l !== GOLD_L) begin errors++; $display("FAIL abort_rerun_sig got %h exp %h", sig_l, GOLD_L); end
    checks++; if (pass_l !== 1'b1) begin errors++; $display("FAIL abort_rerun_pass got %b exp 1", pass_l); end
    tick();
  endtask

  task automatic test_rst_mid_drain();
    int lat;
    start_long();
    repeat (260) tick();
    checks++; if ({busy_l, core_rst_l, core_cen_l} !== 3'b101) begin errors++; $display("FAIL drain_state got busy/rst/cen=%b exp 101", {busy_l, core_rst_l, core_cen_l}); end
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if ({core_rst_l, core_cen_l, core_ina_l, core_inb_l, busy_l, done_l, pass_l} !== 7'b1000000) begin
      errors++;
      $display("FAIL async_rst_ctrl got %b exp 1000000",
               {core_rst_l, core_cen_l, core_ina_l, core_inb_l, busy_l, done_l, pass_l});
    end
    checks++; if (sig_l !== 16'h0000) begin errors++; $display("FAIL async_rst_sig got %h exp 0000", sig_l); end
    tick();
    rst = 1'b1;
    tick();
    start_long();
    wait_done_l(1, lat);
    checks++; if (lat !== LAT_L) begin errors++; $display("FAIL post_rst_latency got %0d exp %0d", lat, LAT_L); end
    checks++; if (sig_l !== GOLD_L) begin errors++; $display("FAIL post_rst_sig got %h exp %h", sig_l, GOLD_L); end
    checks++; if (pass_l !== 1'b1) begin errors++; $display("FAIL post_rst_pass got %b exp 1", pass_l); end
  endtask

  initial begin
    test_reset();
    test_short_run();
    test_loopback();
    test_start_mid_run();
    test_abort();
    test_rst_mid_drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
